// File: rtl/irrigation_tick_timer_pkg.sv
// Shared types and constants for the irrigation tick timer.
package irrigation_tick_timer_pkg;

  // Watering-cycle FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Tick source selection
  localparam logic MODE_GOT = 1'b0;  // drip rate (clock_Got)
  localparam logic MODE_ASP = 1'b1;  // sprinkler rate (clock_Asp)

endpackage

// File: rtl/irrigation_tick_timer_slow_edge_sync.sv
// Brings one slow divided wave into the clock domain and emits a one-cycle
// tick per rising edge. The tick is registered so the rise-to-tick latency
// is SYNC_STAGES+1 edges and the FSM sees a clean flop output.
module slow_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic async_in,
  output logic tick
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   tick_q;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign tick     = tick_q;

  // Synchronizer chain, history flop and registered rising-edge detect
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      hist_q <= sync_out;
      tick_q <= sync_out & ~hist_q;
    end
  end

endmodule

// File: rtl/irrigation_tick_timer.sv
// Watering-cycle timer: converts the two divided waves into tick enables and
// keeps the valve open for a programmed number of ticks of the chosen rate.
module irrigation_tick_timer
  import irrigation_tick_timer_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DUR_W       = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clock_Got,
  input  logic             clock_Asp,
  input  logic             start,
  input  logic             mode,
  input  logic [DUR_W-1:0] duration,
  input  logic             abort,
  output logic             tick_got,
  output logic             tick_asp,
  output logic             busy,
  output logic             valve_on,
  output logic [DUR_W-1:0] remaining,
  output logic             done,
  output logic             aborted
);

  localparam logic [DUR_W-1:0] ONE = {{(DUR_W-1){1'b0}}, 1'b1};

  state_e           state_q;
  logic             mode_q;
  logic [DUR_W-1:0] rem_q;
  logic             busy_q;
  logic             valve_q;
  logic             done_q;
  logic             aborted_q;
  logic             sel_tick;

  slow_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_got (
    .clock    (clock),
    .reset_n  (reset_n),
    .async_in (clock_Got),
    .tick     (tick_got)
  );

  slow_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_asp (
    .clock    (clock),
    .reset_n  (reset_n),
    .async_in (clock_Asp),
    .tick     (tick_asp)
  );

  // Only the source latched at start advances the cycle
  assign sel_tick = (mode_q == MODE_ASP) ? tick_asp : tick_got;

  // Cycle FSM with the remaining-tick counter and registered status outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_GOT;
      rem_q     <= '0;
      busy_q    <= 1'b0;
      valve_q   <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (duration != '0) begin
              mode_q  <= mode;
              rem_q   <= duration;
              busy_q  <= 1'b1;
              state_q <= ST_ARM;
            end else begin
              // zero-length cycle completes without opening the valve
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_ARM: begin
          if (abort) begin
            rem_q     <= '0;
            busy_q    <= 1'b0;
            aborted_q <= 1'b1;
            state_q   <= ST_IDLE;
          end else if (sel_tick) begin
            // aligning tick: open the valve, count starts on the next tick
            valve_q <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            rem_q     <= '0;
            busy_q    <= 1'b0;
            valve_q   <= 1'b0;
            aborted_q <= 1'b1;
            state_q   <= ST_IDLE;
          end else if (sel_tick) begin
            if (rem_q <= ONE) begin
              rem_q   <= '0;
              busy_q  <= 1'b0;
              valve_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              rem_q <= rem_q - ONE;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign valve_on  = valve_q;
  assign remaining = rem_q;
  assign done      = done_q;
  assign aborted   = aborted_q;

endmodule

// File: doc/irrigation_tick_timer.md
Name: irrigation_tick_timer

Overview:
Consumer end of the divider outputs. It takes the slow ripple-derived waves `clock_Got` (drip rate) and `clock_Asp` (sprinkler rate) back into the main `clock` domain and synchronizes them. It turns each rising edge into a single-cycle tick enable, then uses those ticks to time one watering cycle: it drives the valve for a programmed number of ticks of the selected method and reports completion.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops per slow input (minimum 2).
- DUR_W, 8, width of the duration and remaining-count fields.

Ports:
- clock  in  1  system clock; the divider input runs on the same clock.
- reset_n  in  1  asynchronous, active-low reset.
- clock_Got  in  1  divided drip-rate wave; asynchronous to `clock` (ripple output).
- clock_Asp  in  1  divided sprinkler-rate wave; asynchronous to `clock`.
- start  in  1  request a watering cycle; sampled only in IDLE.
- mode  in  1  0 = drip (`clock_Got` ticks), 1 = sprinkler (`clock_Asp` ticks); latched on start.
- duration  in  DUR_W  number of ticks the valve stays open; latched on start.
- abort  in  1  cancel the cycle in progress.
- tick_got  out  1  one-cycle pulse per rising edge of `clock_Got`.
- tick_asp  out  1  one-cycle pulse per rising edge of `clock_Asp`.
- busy  out  1  high in ARM and RUN.
- valve_on  out  1  valve drive; high only in RUN.
- remaining  out  DUR_W  ticks left in the current cycle.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse on abort.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - All synchronizer and edge flops go to 0.
  - FSM goes to IDLE.
  - All outputs are 0, including `remaining`.
  - Reset asserted mid-RUN drops `valve_on` immediately, without waiting for a clock edge. Neither `done` nor `aborted` fires.
- Tick path, per input:
  - SYNC_STAGES flops, then one history flop.
  - tick = sync_out & ~history.
  - Latency from input rise to tick is SYNC_STAGES+1 clock edges (3 at default).
  - High-to-low transitions produce no pulse.
  - Tick outputs run in every state, independent of the FSM.
- FSM states: IDLE, ARM, RUN, DONE.
- IDLE:
  - `start`=1 and `duration`>0: latch `mode`, load `remaining`=`duration`, go to ARM.
  - `start`=1 and `duration`=0: go to DONE; the valve never opens.
  - `abort` is ignored in IDLE.
- ARM:
  - Waits for the first tick of the selected source, which aligns the cycle to a full tick period. On that tick, go to RUN.
  - `remaining` is not decremented on the aligning tick.
- RUN:
  - `valve_on`=1.
  - Each selected tick decrements `remaining`.
  - A tick while `remaining`=1 sets `remaining` to 0 and goes to DONE.
  - Ticks of the non-selected source are ignored.
- DONE: `done`=1 for exactly one cycle, `valve_on`=0, then go to IDLE.
- abort:
  - Applies in ARM or RUN: go to IDLE next edge, `valve_on`=0 at that edge, `aborted` pulses one cycle, `remaining` clears to 0.
  - abort and a completing tick in the same cycle: abort wins and `done` does not fire.
- `start` while busy, or in DONE, is ignored. It is not queued.
- `remaining` never wraps below 0.
- `busy` is 1 exactly in ARM and RUN.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE=2'd0, ARM=2'd1, RUN=2'd2, DONE=2'd3);
  - the mode constants MODE_GOT=1'b0 and MODE_ASP=1'b1.
- One sub-module, `slow_edge_sync`:
  - parameter SYNC_STAGES;
  - ports clock, reset_n, async_in, tick;
  - instantiated twice, once per divided input.
- The FSM and the counter stay in the top module.

Test Plan:
- Tick latency: reset, then raise `clock_Got` once and hold high 20 cycles -> `tick_got` high for exactly 1 cycle, 3 edges after the rise; no second pulse; `tick_asp`=0 throughout.
- Drip cycle: `start` with mode=0, duration=3, `clock_Got` period 16 cycles -> busy=1; ARM until the first tick; `valve_on` for exactly 3 tick periods (48 cycles); `remaining` steps 3,2,1,0; `done` pulses once; then IDLE.
- Zero duration: `start` with duration=0 -> `done` pulses on the next edge; `valve_on` and `busy` never assert.
- Source isolation: mode=1, duration=2, toggle `clock_Got` fast and `clock_Asp` slow -> `remaining` changes only on `tick_asp`.
- Abort mid-RUN with remaining=2 -> next edge `valve_on`=0, `aborted`=1 for one cycle, `remaining`=0, `done` never fires. Repeat with abort coincident with the final tick -> `aborted`=1, `done`=0.
- Async reset mid-RUN, and start while busy:
  - assert reset_n=0 between clock edges -> `valve_on` drops immediately; all outputs 0; after release the FSM is in IDLE.
  - a `start` with duration=5 issued during RUN of duration 2 -> run ends after 2 ticks.
